// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit: one CHUNK-bit slice per stage, carry rippled through registers.
// Optional signed-overflow output `ovf` is built only when ADDER_OVF_EN is defined.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] CHUNK_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

    logic adv;

    // Entry k holds an operation before chunk k has been added; entry 0 is the capture register.
    logic             valid_reg [STAGES];
    logic [WIDTH-1:0] a_reg     [STAGES];
    logic [WIDTH-1:0] b_reg     [STAGES];
    logic [WIDTH-1:0] res_reg   [STAGES];
    logic             carry_reg [STAGES];

    logic [WIDTH-1:0] res_next   [STAGES];
    logic             carry_next [STAGES];

    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    // The whole pipe moves as one unit whenever the result slot is empty or being drained.
    assign adv      = ~out_valid_reg | out_ready;
    assign in_ready = adv;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [CHUNK:0] chunk_sum;

            assign chunk_sum = {1'b0, a_reg[gi][gi*CHUNK +: CHUNK]}
                             + {1'b0, b_reg[gi][gi*CHUNK +: CHUNK]}
                             + (CHUNK+1)'(carry_reg[gi]);

            assign res_next[gi] = (res_reg[gi] & ~(CHUNK_MASK << (gi*CHUNK)))
                                | (WIDTH'(chunk_sum[CHUNK-1:0]) << (gi*CHUNK));
            assign carry_next[gi] = chunk_sum[CHUNK];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_reg[k] <= 1'b0;
                a_reg[k]     <= '0;
                b_reg[k]     <= '0;
                res_reg[k]   <= '0;
                carry_reg[k] <= 1'b0;
            end
        end else if (adv) begin
            valid_reg[0] <= in_valid;
            if (in_valid) begin
                // Subtraction folds into addition: a + ~b + 1.
                a_reg[0]     <= a;
                b_reg[0]     <= sub ? ~b : b;
                carry_reg[0] <= sub | cin;
                res_reg[0]   <= '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                valid_reg[k] <= valid_reg[k-1];
                a_reg[k]     <= a_reg[k-1];
                b_reg[k]     <= b_reg[k-1];
                res_reg[k]   <= res_next[k-1];
                carry_reg[k] <= carry_next[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= valid_reg[STAGES-1];
            if (valid_reg[STAGES-1]) begin
                sum_reg  <= res_next[STAGES-1];
                cout_reg <= carry_next[STAGES-1];
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;

`ifdef ADDER_OVF_EN
    logic ovf_reg;

    // Overflow: like-signed operands producing a result of the opposite sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (adv && valid_reg[STAGES-1]) begin
            ovf_reg <= (a_reg[STAGES-1][WIDTH-1] == b_reg[STAGES-1][WIDTH-1])
                     & (res_next[STAGES-1][WIDTH-1] != a_reg[STAGES-1][WIDTH-1]);
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomised and directed bench for pipelined_adder (WIDTH=16, STAGES=4) against an arithmetic reference.
module tb_pipelined_adder;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_EN
    logic             ovf;
`endif

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
        int          st;
    } exp_t;

    exp_t q[$];
    exp_t none;
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    int   stall_cnt = 0;
    int   stray = 0;
    int   stale = 0;
    logic        hold_pending = 1'b0;
    logic [15:0] held_sum;
    logic        held_cout;
    logic        held_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, overflow from the signed range.
    function automatic exp_t ref_op(input logic [15:0] ia, ib, input logic icin, isub);
        exp_t        r;
        int unsigned beff;
        int unsigned ci;
        int unsigned full;
        int          sres;
        beff = isub ? (~{16'h0, ib} & 32'hFFFF) : {16'h0, ib};
        ci   = isub ? 1 : (icin ? 1 : 0);
        full = {16'h0, ia} + beff + ci;
        sres = int'($signed(ia)) + int'($signed(beff[15:0])) + int'(ci);
        r.s   = full[15:0];
        r.c   = full[16];
        r.o   = (sres > 32767) || (sres < -32768);
        r.acc = 0;
        r.st  = 0;
        return r;
    endfunction

    // One clock: drive at the falling edge, evaluate handshakes 1 time unit later.
    task automatic cycle(input logic iv, input logic [15:0] ia, ib, input logic icin, isub, ordy,
                         input logic use_exp, input exp_t e);
        exp_t n;
        exp_t p;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = icin;
        sub       = isub;
        out_ready = ordy;
        #1;
        if (hold_pending) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_sum", 32'(sum), 32'(held_sum));
            check("hold_cout", 32'(cout), 32'(held_cout));
`ifdef ADDER_OVF_EN
            check("hold_ovf", 32'(ovf), 32'(held_ovf));
`endif
        end
        if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 0);
        if (in_valid && in_ready) begin
            n = use_exp ? e : ref_op(a, b, cin, sub);
            n.acc = edge_cnt;
            n.st  = stall_cnt;
            q.push_back(n);
            $display("in  a=%h b=%h cin=%0d sub=%0d", a, b, cin, sub);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                stray++;
                $display("out sum=%h cout=%0d with nothing outstanding", sum, cout);
            end else begin
                p = q.pop_front();
                $display("out sum=%h cout=%0d (want %h/%0d)", sum, cout, p.s, p.c);
                check("sum", 32'(sum), 32'(p.s));
                check("cout", 32'(cout), 32'(p.c));
`ifdef ADDER_OVF_EN
                check("ovf", 32'(ovf), 32'(p.o));
`endif
                check("latency", 32'(edge_cnt - p.acc - (stall_cnt - p.st)), STAGES + 1);
            end
        end
        hold_pending = out_valid && !out_ready;
        held_sum     = sum;
        held_cout    = cout;
`ifdef ADDER_OVF_EN
        held_ovf     = ovf;
`else
        held_ovf     = 1'b0;
`endif
        if (!in_ready) stall_cnt++;
        edge_cnt++;
    endtask

    task automatic op(input logic [15:0] ia, ib, input logic icin, isub,
                      input logic [15:0] es, input logic ec, eo);
        exp_t e;
        e.s = es; e.c = ec; e.o = eo; e.acc = 0; e.st = 0;
        cycle(1'b1, ia, ib, icin, isub, 1'b1, 1'b1, e);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy, 1'b0, none);
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] corners [4];
        corners[0] = 16'h0000; corners[1] = 16'hFFFF;
        corners[2] = 16'h7FFF; corners[3] = 16'h8000;
        if ($urandom_range(0, 4) == 0) return corners[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    initial begin
        none = '{default: 0};
        #3;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        idle(1'b1);
        idle(1'b1);
        rst_n = 1'b1;

        // Wrap-around, subtraction with and without borrow
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (6) idle(1'b1);
        op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        repeat (6) idle(1'b1);
        // Back-to-back, no gaps
        op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        op(16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
        op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        // Signed overflow corners
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        repeat (8) idle(1'b1);

        // Full pipe held for three cycles, then released
        for (int i = 0; i < 8; i++)
            cycle(1'b1, pick(), pick(), 1'($urandom), 1'($urandom), (i < 5) ? 1'b1 : 1'b0, 1'b0, none);
        repeat (10) idle(1'b1);
        check("drain_after_hold", 32'(q.size()), 0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 7, pick(), pick(), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, 1'b0, none);
        repeat (20) idle(1'b1);
        check("drain_after_random", 32'(q.size()), 0);

        // Reset while operations are in flight and a result is being held
        for (int i = 0; i < 6; i++)
            cycle(1'b1, pick(), pick(), 1'($urandom), 1'($urandom), 1'b0, 1'b0, none);
        check("pre_rst_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 0);
        check("async_rst_sum", 32'(sum), 0);
        check("async_rst_cout", 32'(cout), 0);
`ifdef ADDER_OVF_EN
        check("async_rst_ovf", 32'(ovf), 0);
`endif
        $display("reset asserted with %0d results discarded", q.size());
        q.delete();
        hold_pending = 1'b0;
        idle(1'b1);
        idle(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            idle(1'b1);
            if (out_valid) stale++;
        end
        check("no_stale_after_rst", 32'(stale), 0);

        // Pipe still works after reset
        op(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        repeat (8) idle(1'b1);
        check("no_stray_output", 32'(stray), 0);
        check("final_drain", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
